rgb_colour_matcher: RTL and testbench

- Reverse of the colour-to-RGB converter: takes a 24-bit RGB value and returns the 3-bit colour index of the closest palette entry.
- Closeness is the Manhattan (sum of absolute channel differences) distance.
- Palette is an internal 8-entry register file; it resets to the standard colour table and can be rewritten through a write port.
- Sits after pixel capture/processing: turns arbitrary RGB into palette codes for the display/LED logic.

---
 rtl/rgb_colour_matcher.sv | 118 +++++++++++
 tb/tb_rgb_colour_matcher.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rgb_colour_matcher.sv
// rtl/rgb_colour_matcher.sv - nearest-palette-entry matcher using Manhattan RGB distance
// Sequential search over an 8-entry writable palette, one entry per cycle.
module rgb_colour_matcher #(
  parameter  int CH_W      = 8,
  parameter  int N_ENTRIES = 8,
  localparam int IDX_W     = $clog2(N_ENTRIES),
  localparam int RGB_W     = 3 * CH_W,
  localparam int D_W       = CH_W + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RGB_W-1:0] rgb_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] colour_out,
  output logic [D_W-1:0]   dist_out,
  output logic             exact,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [RGB_W-1:0] wr_data,
  output logic             wr_ready
);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);

  state_t           r_state, w_next;
  logic [RGB_W-1:0] r_pal [N_ENTRIES];
  logic [RGB_W-1:0] r_rgb;
  logic [IDX_W-1:0] r_idx;
  logic [D_W-1:0]   r_best_dist;
  logic [IDX_W-1:0] r_best_idx;
  logic [IDX_W-1:0] r_colour;
  logic [D_W-1:0]   r_dist;
  logic             r_exact;

  logic [RGB_W-1:0] w_entry;
  logic [D_W-1:0]   w_dist;
  logic             w_better;
  logic [D_W-1:0]   w_cand_dist;
  logic [IDX_W-1:0] w_cand_idx;

  function automatic logic [CH_W-1:0] abs_diff(input logic [CH_W-1:0] a, input logic [CH_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  assign w_entry = r_pal[r_idx];
  assign w_dist  = D_W'(abs_diff(r_rgb[3*CH_W-1:2*CH_W], w_entry[3*CH_W-1:2*CH_W]))
                 + D_W'(abs_diff(r_rgb[2*CH_W-1:CH_W],   w_entry[2*CH_W-1:CH_W]))
                 + D_W'(abs_diff(r_rgb[CH_W-1:0],        w_entry[CH_W-1:0]));

  // Strict less-than keeps the lowest index on ties.
  assign w_better    = (w_dist < r_best_dist);
  assign w_cand_dist = w_better ? w_dist : r_best_dist;
  assign w_cand_idx  = w_better ? r_idx  : r_best_idx;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (in_valid)          w_next = S_SEARCH;
      S_SEARCH: if (r_idx == LAST_IDX) w_next = S_DONE;
      S_DONE:   if (out_ready)         w_next = S_IDLE;
      default:                         w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rgb       <= '0;
      r_idx       <= '0;
      r_best_dist <= '1;
      r_best_idx  <= '0;
      r_colour    <= '0;
      r_dist      <= '0;
      r_exact     <= 1'b0;
      // Entry index bits map to R, G, B full-on: the standard 8-colour table.
      for (int k = 0; k < N_ENTRIES; k++) begin
        r_pal[k] <= {{CH_W{k[2]}}, {CH_W{k[1]}}, {CH_W{k[0]}}};
      end
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (wr_en) r_pal[wr_addr] <= wr_data;
          if (in_valid) begin
            r_rgb       <= rgb_in;
            r_idx       <= '0;
            r_best_dist <= '1;
            r_best_idx  <= '0;
          end
        end
        S_SEARCH: begin
          r_best_dist <= w_cand_dist;
          r_best_idx  <= w_cand_idx;
          r_idx       <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            r_colour <= w_cand_idx;
            r_dist   <= w_cand_dist;
            r_exact  <= (w_cand_dist == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign wr_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign colour_out = r_colour;
  assign dist_out   = r_dist;
  assign exact      = r_exact;

endmodule

// File: tb/tb_rgb_colour_matcher.sv
// tb/tb_rgb_colour_matcher.sv - self-checking bench for rgb_colour_matcher
// Expected results come from a reference palette model and are queued at request time.
module tb_rgb_colour_matcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] rgb_in;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  colour_out;
  logic [9:0]  dist_out;
  logic        exact;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [23:0] wr_data;
  logic        wr_ready;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0;

  logic [23:0] m_pal [8];
  logic [12:0] sb_q [$];

  rgb_colour_matcher dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .rgb_in(rgb_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .colour_out(colour_out), .dist_out(dist_out), .exact(exact),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int chd(input logic [7:0] a, input logic [7:0] b);
    int d;
    d = int'(a) - int'(b);
    return (d < 0) ? -d : d;
  endfunction

  function automatic logic [12:0] model(input logic [23:0] c);
    int best_d;
    int best_i;
    int d;
    best_d = 100000;
    best_i = 0;
    for (int k = 0; k < 8; k++) begin
      d = chd(c[23:16], m_pal[k][23:16]) + chd(c[15:8], m_pal[k][15:8]) + chd(c[7:0], m_pal[k][7:0]);
      if (d < best_d) begin
        best_d = d;
        best_i = k;
      end
    end
    return {3'(best_i), 10'(best_d)};
  endfunction

  task automatic model_reset();
    m_pal[0] = 24'h000000; m_pal[1] = 24'h0000FF; m_pal[2] = 24'h00FF00; m_pal[3] = 24'h00FFFF;
    m_pal[4] = 24'hFF0000; m_pal[5] = 24'hFF00FF; m_pal[6] = 24'hFFFF00; m_pal[7] = 24'hFFFFFF;
  endtask

  task automatic start_req(input logic [23:0] c);
    check("in_ready_before_req", in_ready, 1'b1);
    in_valid = 1'b1;
    rgb_in   = c;
    t0       = cyc;
    sb_q.push_back(model(c));
    @(negedge clk);
    in_valid = 1'b0;
    rgb_in   = 24'h5A5A5A;
  endtask

  task automatic finish_req(input string tag);
    logic [12:0] e;
    while (!out_valid && (cyc - t0) < 60) @(negedge clk);
    check({tag, "_latency"}, cyc - t0, 9);
    if (sb_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 0, 1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_colour"}, colour_out, e[12:10]);
      check({tag, "_dist"},   dist_out,   e[9:0]);
      check({tag, "_exact"},  exact,      e[9:0] == 10'd0);
    end
  endtask

  task automatic run_req(input string tag, input logic [23:0] c);
    start_req(c);
    finish_req(tag);
    @(negedge clk);
    check({tag, "_valid_drop"}, out_valid, 1'b0);
    check({tag, "_ready_back"}, in_ready, 1'b1);
  endtask

  initial begin
    logic [2:0] held_colour;
    logic [9:0] held_dist;
    rst = 1'b1; in_valid = 1'b0; rgb_in = '0; out_ready = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready",  in_ready,   1'b1);
    check("rst_out_valid", out_valid,  1'b0);
    check("rst_colour",    colour_out, 3'd0);
    check("rst_dist",      dist_out,   10'd0);
    check("rst_exact",     exact,      1'b0);
    check("rst_wr_ready",  wr_ready,   1'b1);

    run_req("red", 24'hFF0000);
    check("red_const_colour", colour_out, 3'd4);
    run_req("greenish", 24'h10F020);
    check("greenish_const_dist", dist_out, 10'd63);
    run_req("grey7f", 24'h7F7F7F);
    check("grey7f_const_colour", colour_out, 3'd0);
    run_req("grey80", 24'h808080);
    check("grey80_const_colour", colour_out, 3'd7);

    // Palette write in IDLE, then match the new value exactly.
    check("wr_ready_idle", wr_ready, 1'b1);
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 24'h123456;
    @(negedge clk);
    wr_en = 1'b0;
    m_pal[3] = 24'h123456;
    run_req("custom3", 24'h123456);
    check("custom3_const_colour", colour_out, 3'd3);

    // Writes attempted during SEARCH must be dropped.
    start_req(24'hFF00FF);
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 24'h000001;
    check("wr_ready_search", wr_ready, 1'b0);
    repeat (3) @(negedge clk);
    wr_en = 1'b0;
    finish_req("mag_a");
    @(negedge clk);
    run_req("mag_b", 24'hFF00FF);
    check("mag_b_const_colour", colour_out, 3'd5);

    // Backpressure: hold the result, ignore new requests.
    out_ready = 1'b0;
    start_req(24'h00F0F0);
    finish_req("bp");
    held_colour = colour_out;
    held_dist   = dist_out;
    in_valid = 1'b1; rgb_in = 24'hFFFFFF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_valid_held", out_valid, 1'b1);
      check("bp_in_ready",   in_ready,  1'b0);
      check("bp_colour",     colour_out, held_colour);
      check("bp_dist",       dist_out,   held_dist);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", out_valid, 1'b0);
    check("bp_release_ready", in_ready,  1'b1);
    repeat (12) @(negedge clk);
    check("bp_no_extra_result", out_valid, 1'b0);

    // Reset mid-search restores the default palette.
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 24'hABCDEF;
    @(negedge clk);
    wr_en = 1'b0;
    m_pal[1] = 24'hABCDEF;
    start_req(24'h0000FF);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    model_reset();
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_in_ready",  in_ready,  1'b1);
    run_req("blue_after_rst", 24'h0000FF);
    check("blue_const_colour", colour_out, 3'd1);
    check("blue_const_exact",  exact,      1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
